priv_hpm_counters: RTL and testbench
====================================

PRIV_HPM_COUNTERS -- requirements
Module: priv_hpm_counters

Interface
REQ-001 SHALL have parameter NUM_COUNTERS, default 4, number of counters (legal 1..29).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 64, bits per counter (legal 33..64).
REQ-003 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port event_in  input  NUM_COUNTERS  per-counter increment-by-1 request.
REQ-006 SHALL have port inhibit  input  NUM_COUNTERS  per-counter count inhibit (mcountinhibit image).
REQ-007 SHALL have port wr_en  input  1  CSR write strobe.
REQ-008 SHALL have port wr_idx  input  IDXW=max(1,$clog2(NUM_COUNTERS))  counter selected for the write.
REQ-009 SHALL have port wr_hi  input  1  write targets the upper half (bits COUNTER_WIDTH-1:32).
REQ-010 SHALL have port wdata  input  32  write data.
REQ-011 SHALL have port rd_req  input  1  read strobe.
REQ-012 SHALL have port rd_idx  input  IDXW  counter selected for the read.
REQ-013 SHALL have port rd_hi  input  1  read targets the upper half.
REQ-014 SHALL have port rdata  output  32  read data, valid when rd_valid is high.
REQ-015 SHALL have port rd_valid  output  1  one-cycle pulse, one cycle after rd_req.
REQ-016 SHALL have port ovf_clr  input  NUM_COUNTERS  clears sticky overflow flags (HPM_OVF_IRQ_EN only).
REQ-017 SHALL have ports ovf  output  NUM_COUNTERS  sticky overflow flags, and ovf_irq  output  1  OR of ovf (HPM_OVF_IRQ_EN only).

Function
REQ-018 Counter i SHALL increment by 1 per cycle when event_in[i]=1 and inhibit[i]=0, with no other effect.
REQ-019 Counters SHALL wrap from 2^COUNTER_WIDTH-1 to 0.
REQ-020 A write SHALL update only the selected half of counter wr_idx next cycle; the other half is held.
REQ-021 An upper-half write SHALL keep wdata[COUNTER_WIDTH-33:0] and discard the remaining bits.
REQ-022 A write SHALL win over a same-cycle increment of the same counter; the increment is lost and the counter is not overflowed.
REQ-023 Reads SHALL be registered: rd_req in cycle N gives rdata/rd_valid in cycle N+1 from counter state before the cycle-N edge.
REQ-024 A low-half read of counter i SHALL latch its current upper bits into shadow[i] and set snap_vld[i].
REQ-025 An upper-half read of counter i SHALL return shadow[i] and clear snap_vld[i] when snap_vld[i]=1, and the live upper bits otherwise.
REQ-026 Upper-half reads SHALL zero-extend to 32 bits.
REQ-027 Any write to counter i SHALL clear snap_vld[i].
REQ-028 wr_idx or rd_idx >= NUM_COUNTERS SHALL make the write a no-op, and the read SHALL return rdata=0 with rd_valid still pulsed.
REQ-029 When rd_valid=0, rdata SHALL be 0.

Reset
REQ-030 nRST low SHALL immediately force all counters, shadow, snap_vld, ovf, rdata, rd_valid and ovf_irq to 0.
REQ-031 A read or write in progress at reset assertion SHALL be discarded, with no pulse after release.

Configuration
REQ-032 With HPM_OVF_IRQ_EN defined, an increment wrapping counter i SHALL set ovf[i].
REQ-033 With HPM_OVF_IRQ_EN defined, ovf[i] SHALL hold until ovf_clr[i]; a same-cycle set SHALL win over the clear.
REQ-034 With HPM_OVF_IRQ_EN defined, ovf_irq SHALL equal OR(ovf), registered.
REQ-035 Without HPM_OVF_IRQ_EN, ovf and ovf_irq SHALL be tied to 0, ovf_clr SHALL be ignored, and no overflow flops SHALL exist.

Structure
REQ-036 Package priv_hpm_pkg SHALL hold the CSR address constants MHPMCOUNTER3_ADDR=12'hB03, MHPMCOUNTERH3_ADDR=12'hB83 and MCOUNTINHIBIT_ADDR=12'h320.
REQ-037 priv_hpm_pkg SHALL hold the struct hpm_rd_req_t {idx, hi}; CSR address decode stays outside this block.
REQ-038 One sub-module, hpm_counter, SHALL implement a single counter slice (count, half-write, wrap detect), generated NUM_COUNTERS times.

Verification
REQ-039 event_in[0]=1 with inhibit=0 for 10 cycles -> counter 0 low read returns 10; inhibit[0]=1 for 5 more cycles -> still 10.
REQ-040 Write counter 1 low=FFFFFFFF and hi=0, then one event -> low read returns 0 and hi read returns 1.
REQ-041 Counter at 0x0000_0000_FFFF_FFFF, low read, then increment, then hi read -> hi read returns 0 (shadow), a second hi read returns 1.
REQ-042 Write counter 2 low=5 in the same cycle as event_in[2] -> read returns 5.
REQ-043 With HPM_OVF_IRQ_EN, counter at all-ones plus one event -> ovf[0]=1 and ovf_irq=1 the cycle after; ovf_clr[0] -> both 0.
REQ-044 nRST asserted mid-count and during rd_req -> all outputs 0 at once, and no rd_valid after release.

Source files
------------

// File: rtl/priv_hpm_pkg.sv
// Shared constants and types for the hardware performance-monitor counter block.
// CSR address decode lives outside this block; these constants are for the decoder.
package priv_hpm_pkg;

  localparam logic [11:0] MHPMCOUNTER3_ADDR  = 12'hB03;
  localparam logic [11:0] MHPMCOUNTERH3_ADDR = 12'hB83;
  localparam logic [11:0] MCOUNTINHIBIT_ADDR = 12'h320;

  localparam int unsigned MaxCounters = 29;
  localparam int unsigned HpmIdxW     = 5;

  typedef struct packed {
    logic [HpmIdxW-1:0] idx;
    logic               hi;
  } hpm_rd_req_t;

endpackage

// File: rtl/hpm_counter.sv
// One performance counter slice: increment, half-word write and wrap detection.
// A write always wins over a same-cycle increment; the increment is dropped.
module hpm_counter
  import priv_hpm_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     inc_en,
  input  logic                     wr_en,
  input  logic                     wr_hi,
  input  logic [31:0]              wdata,
  output logic [COUNTER_WIDTH-1:0] cnt,
  output logic                     wrap
);

  localparam int unsigned UpperW = COUNTER_WIDTH - 32;

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (wr_en) begin
      if (wr_hi) begin
        cnt_d[COUNTER_WIDTH-1:32] = wdata[UpperW-1:0];
      end else begin
        cnt_d[31:0] = wdata;
      end
    end else if (inc_en) begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
      wrap  = &cnt_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/priv_hpm_counters.sv
// Bank of HPM counters with registered 32-bit reads and a per-counter upper-half snapshot.
// Optional sticky overflow flags and interrupt are built only with HPM_OVF_IRQ_EN defined.
module priv_hpm_counters
  import priv_hpm_pkg::*;
#(
  parameter int unsigned NUM_COUNTERS  = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  localparam int unsigned IDXW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NUM_COUNTERS-1:0] event_in,
  input  logic [NUM_COUNTERS-1:0] inhibit,
  input  logic                    wr_en,
  input  logic [IDXW-1:0]         wr_idx,
  input  logic                    wr_hi,
  input  logic [31:0]             wdata,
  input  logic                    rd_req,
  input  logic [IDXW-1:0]         rd_idx,
  input  logic                    rd_hi,
  output logic [31:0]             rdata,
  output logic                    rd_valid,
  input  logic [NUM_COUNTERS-1:0] ovf_clr,
  output logic [NUM_COUNTERS-1:0] ovf,
  output logic                    ovf_irq
);

  localparam int unsigned        UpperW = COUNTER_WIDTH - 32;
  localparam logic [HpmIdxW-1:0] NumCnt = HpmIdxW'(NUM_COUNTERS);

  logic [COUNTER_WIDTH-1:0] cnt [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  wrap;
  logic                     wr_ok;
  hpm_rd_req_t              rd_s;

  logic [UpperW-1:0]       shadow_q [NUM_COUNTERS];
  logic [UpperW-1:0]       shadow_d [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] snap_vld_q, snap_vld_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rd_valid_q, rd_valid_d;

  // Out-of-range indices never match a slice, so such writes fall through as no-ops.
  assign wr_ok = wr_en && (HpmIdxW'(wr_idx) < NumCnt);
  assign rd_s  = '{idx: HpmIdxW'(rd_idx), hi: rd_hi};

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    hpm_counter #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc_en(event_in[i] & ~inhibit[i]),
      .wr_en (wr_ok && (wr_idx == IDXW'(i))),
      .wr_hi (wr_hi),
      .wdata (wdata),
      .cnt   (cnt[i]),
      .wrap  (wrap[i])
    );
  end

  always_comb begin
    rd_valid_d = rd_req;
    rdata_d    = '0;
    shadow_d   = shadow_q;
    snap_vld_d = snap_vld_q;
    if (rd_req && (rd_s.idx < NumCnt)) begin
      if (!rd_s.hi) begin
        rdata_d            = cnt[rd_idx][31:0];
        shadow_d[rd_idx]   = cnt[rd_idx][COUNTER_WIDTH-1:32];
        snap_vld_d[rd_idx] = 1'b1;
      end else if (snap_vld_q[rd_idx]) begin
        rdata_d            = 32'(shadow_q[rd_idx]);
        snap_vld_d[rd_idx] = 1'b0;
      end else begin
        rdata_d = 32'(cnt[rd_idx][COUNTER_WIDTH-1:32]);
      end
    end
    // A write invalidates any pending snapshot, even one taken this same cycle.
    if (wr_ok) begin
      snap_vld_d[wr_idx] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      shadow_q   <= '{default: '0};
      snap_vld_q <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      snap_vld_q <= snap_vld_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
  logic                    ovf_irq_q, ovf_irq_d;

  // Set wins over a same-cycle clear.
  always_comb begin
    ovf_d     = (ovf_q & ~ovf_clr) | wrap;
    ovf_irq_d = |ovf_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_q     <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_irq_q <= ovf_irq_d;
    end
  end

  assign ovf     = ovf_q;
  assign ovf_irq = ovf_irq_q;
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr, wrap};
  assign ovf        = '0;
  assign ovf_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_priv_hpm_counters.sv
// Directed bench for priv_hpm_counters: reads go through an expected-value queue.
// A second instance (3 counters, 40 bits) covers out-of-range indices and upper-half truncation.
module tb_priv_hpm_counters;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  event_in, inhibit, ovf_clr, ovf;
  logic        wr_en, wr_hi, rd_req, rd_hi, rd_valid, ovf_irq;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] wdata, rdata;

  logic [2:0]  ev_b, inh_b, ovf_clr_b, ovf_b;
  logic        wr_en_b, wr_hi_b, rd_req_b, rd_hi_b, rd_valid_b, ovf_irq_b;
  logic [1:0]  wr_idx_b, rd_idx_b;
  logic [31:0] wdata_b, rdata_b;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  priv_hpm_counters #(.NUM_COUNTERS(4), .COUNTER_WIDTH(64)) u_dut (
    .CLK(CLK), .nRST(nRST), .event_in(event_in), .inhibit(inhibit),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hi(wr_hi), .wdata(wdata),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_hi(rd_hi), .rdata(rdata), .rd_valid(rd_valid),
    .ovf_clr(ovf_clr), .ovf(ovf), .ovf_irq(ovf_irq)
  );

  priv_hpm_counters #(.NUM_COUNTERS(3), .COUNTER_WIDTH(40)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .event_in(ev_b), .inhibit(inh_b),
    .wr_en(wr_en_b), .wr_idx(wr_idx_b), .wr_hi(wr_hi_b), .wdata(wdata_b),
    .rd_req(rd_req_b), .rd_idx(rd_idx_b), .rd_hi(rd_hi_b), .rdata(rdata_b),
    .rd_valid(rd_valid_b), .ovf_clr(ovf_clr_b), .ovf(ovf_b), .ovf_irq(ovf_irq_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input bit b, input logic [1:0] idx, input bit hi,
                         input logic [31:0] exp, input string tag);
    logic [31:0] want;
    @(negedge CLK);
    if (b) begin rd_req_b = 1'b1; rd_idx_b = idx; rd_hi_b = hi; end
    else   begin rd_req   = 1'b1; rd_idx   = idx; rd_hi   = hi; end
    exp_q.push_back(exp);
    @(negedge CLK);
    rd_req   = 1'b0;
    rd_req_b = 1'b0;
    check({tag, "/valid"}, b ? 32'(rd_valid_b) : 32'(rd_valid), 32'd1);
    want = exp_q.pop_front();
    check(tag, b ? rdata_b : rdata, want);
  endtask

  task automatic do_write(input bit b, input logic [1:0] idx, input bit hi,
                          input logic [31:0] data, input logic [3:0] ev);
    @(negedge CLK);
    if (b) begin wr_en_b = 1'b1; wr_idx_b = idx; wr_hi_b = hi; wdata_b = data; end
    else   begin wr_en   = 1'b1; wr_idx   = idx; wr_hi   = hi; wdata   = data; end
    event_in = ev;
    @(negedge CLK);
    wr_en    = 1'b0;
    wr_en_b  = 1'b0;
    event_in = '0;
  endtask

  task automatic run_events(input logic [3:0] mask, input logic [3:0] inh, input int n);
    @(negedge CLK);
    event_in = mask;
    inhibit  = inh;
    repeat (n) @(negedge CLK);
    event_in = '0;
    inhibit  = '0;
  endtask

  initial begin
    event_in = '0; inhibit = '0; ovf_clr = '0;
    wr_en = 1'b0; wr_idx = '0; wr_hi = 1'b0; wdata = '0;
    rd_req = 1'b0; rd_idx = '0; rd_hi = 1'b0;
    ev_b = '0; inh_b = '0; ovf_clr_b = '0;
    wr_en_b = 1'b0; wr_idx_b = '0; wr_hi_b = 1'b0; wdata_b = '0;
    rd_req_b = 1'b0; rd_idx_b = '0; rd_hi_b = 1'b0;
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #11;
    check("reset/rdata", rdata, 32'd0);
    check("reset/rd_valid", 32'(rd_valid), 32'd0);
    check("reset/ovf", 32'(ovf), 32'd0);
    check("reset/ovf_irq", 32'(ovf_irq), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Count with and without inhibit
    run_events(4'b0001, 4'b0000, 10);
    run_events(4'b0001, 4'b0001, 5);
    do_read(1'b0, 2'd0, 1'b0, 32'd10, "cnt0_inhibit");
    do_read(1'b0, 2'd0, 1'b1, 32'd0, "cnt0_hi_shadow");
    @(negedge CLK);
    check("idle/rd_valid", 32'(rd_valid), 32'd0);
    check("idle/rdata", rdata, 32'd0);

    // Carry into upper half
    do_write(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 4'b0000);
    do_write(1'b0, 2'd1, 1'b1, 32'h0, 4'b0000);
    run_events(4'b0010, 4'b0000, 1);
    do_read(1'b0, 2'd1, 1'b0, 32'd0, "cnt1_lo_carry");
    do_read(1'b0, 2'd1, 1'b1, 32'd1, "cnt1_hi_carry");

    // Shadow holds the upper half seen at the low read
    do_write(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFF, 4'b0000);
    do_read(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFF, "cnt3_lo");
    run_events(4'b1000, 4'b0000, 1);
    do_read(1'b0, 2'd3, 1'b1, 32'd0, "cnt3_hi_shadow");
    do_read(1'b0, 2'd3, 1'b1, 32'd1, "cnt3_hi_live");

    // Write beats a same-cycle increment
    do_write(1'b0, 2'd2, 1'b0, 32'd5, 4'b0100);
    do_read(1'b0, 2'd2, 1'b0, 32'd5, "cnt2_wr_wins");
    do_read(1'b0, 2'd2, 1'b1, 32'd0, "cnt2_hi_zero");
    do_write(1'b0, 2'd2, 1'b1, 32'hDEAD_BEEF, 4'b0000);
    do_read(1'b0, 2'd2, 1'b1, 32'hDEAD_BEEF, "cnt2_hi_wr");
    do_read(1'b0, 2'd2, 1'b0, 32'd5, "cnt2_lo_held");
    do_read(1'b0, 2'd2, 1'b1, 32'hDEAD_BEEF, "cnt2_hi_snap");

    // A write drops a pending snapshot
    do_read(1'b0, 2'd0, 1'b0, 32'd10, "cnt0_lo_snap");
    do_write(1'b0, 2'd0, 1'b1, 32'd7, 4'b0000);
    do_read(1'b0, 2'd0, 1'b1, 32'd7, "cnt0_snap_cleared");

    // Full wrap
    do_write(1'b0, 2'd3, 1'b0, 32'hFFFF_FFFF, 4'b0000);
    do_write(1'b0, 2'd3, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    @(negedge CLK);
    event_in = 4'b1000;
    @(negedge CLK);
    event_in = '0;
`ifdef HPM_OVF_IRQ_EN
    check("wrap/ovf", 32'(ovf), 32'h8);
    check("wrap/ovf_irq", 32'(ovf_irq), 32'd1);
    ovf_clr = 4'b1000;
    @(negedge CLK);
    ovf_clr = '0;
    check("ovf_clr/ovf", 32'(ovf), 32'd0);
    check("ovf_clr/ovf_irq", 32'(ovf_irq), 32'd0);
`else
    check("wrap/ovf_tied", 32'(ovf), 32'd0);
    check("wrap/ovf_irq_tied", 32'(ovf_irq), 32'd0);
`endif
    do_read(1'b0, 2'd3, 1'b0, 32'd0, "cnt3_wrap_lo");
    do_read(1'b0, 2'd3, 1'b1, 32'd0, "cnt3_wrap_hi");

    // Narrow instance: index 3 is out of range, upper half is 8 bits wide
    do_write(1'b1, 2'd3, 1'b0, 32'd123, 4'b0000);
    do_read(1'b1, 2'd3, 1'b0, 32'd0, "b_oor_read");
    do_read(1'b1, 2'd0, 1'b0, 32'd0, "b_oor_nowrite");
    do_write(1'b1, 2'd1, 1'b1, 32'hFFFF_FFFF, 4'b0000);
    do_read(1'b1, 2'd1, 1'b1, 32'h0000_00FF, "b_hi_trunc");
    do_read(1'b1, 2'd1, 1'b0, 32'd0, "b_lo_held");

    // Reset while a read result is showing, a new read is requested and counting is on
    @(negedge CLK);
    rd_req = 1'b1; rd_idx = 2'd0; rd_hi = 1'b0;
    @(negedge CLK);
    check("pre_reset/rd_valid", 32'(rd_valid), 32'd1);
    check("pre_reset/rdata", rdata, 32'd10);
    event_in = 4'b0001;
    #1 nRST = 1'b0;
    #1;
    check("async_reset/rd_valid", 32'(rd_valid), 32'd0);
    check("async_reset/rdata", rdata, 32'd0);
    check("async_reset/ovf_irq", 32'(ovf_irq), 32'd0);
    rd_req = 1'b0; event_in = '0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("post_reset/no_pulse", 32'(rd_valid), 32'd0);
    do_read(1'b0, 2'd0, 1'b0, 32'd0, "post_reset/cnt0_lo");
    do_read(1'b0, 2'd0, 1'b1, 32'd0, "post_reset/cnt0_hi");
    do_read(1'b0, 2'd2, 1'b1, 32'd0, "post_reset/cnt2_hi");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
